// File: rtl/atm_txn_engine.sv
// ATM transaction engine: owns the per-card account table and runs the card-session FSM
// (card check, PIN entry with lockout, handshaked op menu, inactivity timeout).
module atm_txn_engine #(
  parameter int NUM_CARDS     = 16,
  parameter int BAL_W         = 16,
  parameter int PIN_W         = 16,
  parameter int MAX_PIN_TRIES = 3,
  parameter int TIMEOUT_CYC   = 1023,
  localparam int ID_W         = $clog2(NUM_CARDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_inserted,
  input  logic [ID_W-1:0]  card_id,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin_in,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [BAL_W-1:0] amount,
  input  logic [PIN_W-1:0] new_pin,
  input  logic             day_rollover,
  input  logic             cfg_we,
  input  logic [ID_W-1:0]  cfg_card,
  input  logic [PIN_W-1:0] cfg_pin,
  input  logic [BAL_W-1:0] cfg_balance,
  input  logic [BAL_W-1:0] cfg_limit,
  input  logic             cfg_active,
  output logic [3:0]       state_o,
  output logic             resp_valid,
  output logic             resp_ok,
  output logic [3:0]       error_code,
  output logic [BAL_W-1:0] balance_out
);

  localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_PIN_TRIES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] OP_BAL = 2'd0, OP_WDR = 2'd1, OP_DEP = 2'd2, OP_PINCHG = 2'd3;

  localparam logic [3:0] ERR_NONE = 4'd0, ERR_INVALID = 4'd1, ERR_BAD_PIN = 4'd2,
                         ERR_LOCKED = 4'd3, ERR_INSUF = 4'd4, ERR_LIMIT = 4'd5,
                         ERR_OVERFLOW = 4'd6, ERR_TIMEOUT = 4'd7;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_VALIDATE  = 4'd1,
    S_PIN_WAIT  = 4'd2,
    S_PIN_CHECK = 4'd3,
    S_MENU      = 4'd4,
    S_EXEC      = 4'd5,
    S_DONE      = 4'd6,
    S_ERROR     = 4'd7
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    card_q;
  logic [TRY_W-1:0]   tries;
  logic [TMO_W-1:0]   tmo;
  logic [PIN_W-1:0]   pin_q;
  logic [PIN_W-1:0]   npin_q;
  logic [1:0]         op_q;
  logic [BAL_W-1:0]   amt_q;

  logic [PIN_W-1:0]   pin_tab   [NUM_CARDS];
  logic [BAL_W-1:0]   bal_tab   [NUM_CARDS];
  logic [BAL_W-1:0]   lim_tab   [NUM_CARDS];
  logic [BAL_W-1:0]   spent_tab [NUM_CARDS];
  logic [NUM_CARDS-1:0] act_tab;

  logic [BAL_W-1:0]   cur_bal;
  logic [BAL_W-1:0]   spent_eff;
  logic [BAL_W:0]     wdr_need;
  logic [BAL_W:0]     dep_sum;
  logic               pin_match;
  logic               lock_now;
  logic               cfg_wr;
  logic               commit;
  logic               ex_ok;
  logic [3:0]         ex_err;
  logic [BAL_W-1:0]   ex_bal;
  logic               ex_wdr;
  logic               ex_dep;
  logic               ex_pin;

  assign state_o   = state;
  assign cur_bal   = bal_tab[card_q];
  // A rollover in the commit cycle clears first, so the check sees a zero spent-today.
  assign spent_eff = day_rollover ? '0 : spent_tab[card_q];
  assign wdr_need  = {1'b0, spent_eff} + {1'b0, amt_q};
  assign dep_sum   = {1'b0, cur_bal} + {1'b0, amt_q};
  assign pin_match = (pin_q == pin_tab[card_q]);
  assign lock_now  = (state == S_PIN_CHECK) && card_inserted && !pin_match && (tries == TRY_LAST);
  assign cfg_wr    = cfg_we && (state == S_IDLE);
  assign commit    = (state == S_EXEC);

  always_comb begin
    ex_ok  = 1'b1;
    ex_err = ERR_NONE;
    ex_bal = cur_bal;
    ex_wdr = 1'b0;
    ex_dep = 1'b0;
    ex_pin = 1'b0;
    case (op_q)
      OP_WDR: begin
        if (wdr_need > {1'b0, lim_tab[card_q]}) begin
          ex_ok  = 1'b0;
          ex_err = ERR_LIMIT;
        end else if (amt_q > cur_bal) begin
          ex_ok  = 1'b0;
          ex_err = ERR_INSUF;
        end else begin
          ex_bal = cur_bal - amt_q;
          ex_wdr = 1'b1;
        end
      end
      OP_DEP: begin
        if (dep_sum[BAL_W]) begin
          ex_ok  = 1'b0;
          ex_err = ERR_OVERFLOW;
        end else begin
          ex_bal = dep_sum[BAL_W-1:0];
          ex_dep = 1'b1;
        end
      end
      OP_PINCHG: ex_pin = 1'b1;
      default: ;
    endcase
  end

  // Table control fields: active bits and spent-today counters are cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_tab <= '0;
      for (int i = 0; i < NUM_CARDS; i++) spent_tab[i] <= '0;
    end else begin
      if (day_rollover)
        for (int i = 0; i < NUM_CARDS; i++) spent_tab[i] <= '0;
      if (commit && ex_wdr) spent_tab[card_q] <= wdr_need[BAL_W-1:0];
      if (cfg_wr) act_tab[cfg_card] <= cfg_active;
      if (lock_now) act_tab[card_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      pin_tab[cfg_card] <= cfg_pin;
      bal_tab[cfg_card] <= cfg_balance;
      lim_tab[cfg_card] <= cfg_limit;
    end
    if (commit && (ex_wdr || ex_dep)) bal_tab[card_q] <= ex_bal;
    if (commit && ex_pin) pin_tab[card_q] <= npin_q;
  end

  always_ff @(posedge clk) begin
    if ((state == S_PIN_WAIT) && pin_valid) pin_q <= pin_in;
    if ((state == S_MENU) && op_valid) begin
      op_q   <= op_code;
      amt_q  <= amount;
      npin_q <= new_pin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      card_q      <= '0;
      tries       <= '0;
      tmo         <= '0;
      resp_valid  <= 1'b0;
      resp_ok     <= 1'b0;
      error_code  <= ERR_NONE;
      balance_out <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: if (card_inserted) begin
          card_q     <= card_id;
          error_code <= ERR_NONE;
          tries      <= '0;
          state      <= S_VALIDATE;
        end
        S_VALIDATE: begin
          if (!card_inserted) state <= S_IDLE;
          else if (!act_tab[card_q]) begin
            error_code <= ERR_INVALID;
            state      <= S_ERROR;
          end else begin
            tmo   <= '0;
            state <= S_PIN_WAIT;
          end
        end
        S_PIN_WAIT: begin
          if (!card_inserted) state <= S_IDLE;
          else if (pin_valid) begin
            tmo   <= '0;
            state <= S_PIN_CHECK;
          end else if (tmo == TMO_LAST) begin
            error_code <= ERR_TIMEOUT;
            state      <= S_ERROR;
          end else tmo <= tmo + 1'b1;
        end
        S_PIN_CHECK: begin
          if (!card_inserted) state <= S_IDLE;
          else if (pin_match) begin
            tries <= '0;
            tmo   <= '0;
            state <= S_MENU;
          end else if (tries == TRY_LAST) begin
            error_code <= ERR_LOCKED;
            state      <= S_ERROR;
          end else begin
            tries      <= tries + 1'b1;
            error_code <= ERR_BAD_PIN;
            tmo        <= '0;
            state      <= S_PIN_WAIT;
          end
        end
        S_MENU: begin
          if (!card_inserted) state <= S_IDLE;
          else if (op_valid) begin
            error_code <= ERR_NONE;
            tmo        <= '0;
            state      <= S_EXEC;
          end else if (tmo == TMO_LAST) begin
            error_code <= ERR_TIMEOUT;
            state      <= S_ERROR;
          end else tmo <= tmo + 1'b1;
        end
        // EXEC is atomic: it always commits and reports, even if the card is pulled.
        S_EXEC: begin
          resp_valid <= 1'b1;
          resp_ok    <= ex_ok;
          error_code <= ex_err;
          if (ex_ok) balance_out <= ex_bal;
          state <= S_DONE;
        end
        S_DONE: begin
          tmo   <= '0;
          state <= card_inserted ? S_MENU : S_IDLE;
        end
        S_ERROR: if (!card_inserted) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_txn_engine.sv
// Directed bench for atm_txn_engine: account ops, limits, lockout, overflow, timeout, removal, reset.
module tb_atm_txn_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        card_inserted;
  logic [3:0]  card_id;
  logic        pin_valid;
  logic [15:0] pin_in;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [15:0] amount;
  logic [15:0] new_pin;
  logic        day_rollover;
  logic        cfg_we;
  logic [3:0]  cfg_card;
  logic [15:0] cfg_pin;
  logic [15:0] cfg_balance;
  logic [15:0] cfg_limit;
  logic        cfg_active;
  logic [3:0]  state_o;
  logic        resp_valid;
  logic        resp_ok;
  logic [3:0]  error_code;
  logic [15:0] balance_out;

  int errors = 0;
  int checks = 0;

  atm_txn_engine #(.NUM_CARDS(16), .BAL_W(16), .PIN_W(16), .MAX_PIN_TRIES(3), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .card_inserted(card_inserted), .card_id(card_id),
    .pin_valid(pin_valid), .pin_in(pin_in), .op_valid(op_valid), .op_code(op_code),
    .amount(amount), .new_pin(new_pin), .day_rollover(day_rollover), .cfg_we(cfg_we),
    .cfg_card(cfg_card), .cfg_pin(cfg_pin), .cfg_balance(cfg_balance), .cfg_limit(cfg_limit),
    .cfg_active(cfg_active), .state_o(state_o), .resp_valid(resp_valid), .resp_ok(resp_ok),
    .error_code(error_code), .balance_out(balance_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic insert(input logic [3:0] id);
    card_inserted = 1'b1;
    card_id = id;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic remove();
    card_inserted = 1'b0;
    @(negedge clk);
    chk("remove state", state_o, 0);
  endtask

  task automatic enter_pin(input logic [15:0] p);
    pin_valid = 1'b1;
    pin_in = p;
    @(negedge clk);
    pin_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic cfg(input logic [3:0] c, input logic [15:0] p, input logic [15:0] b,
                     input logic [15:0] l, input logic a);
    cfg_we = 1'b1; cfg_card = c; cfg_pin = p; cfg_balance = b; cfg_limit = l; cfg_active = a;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] code, input logic [15:0] amt,
                       input logic [15:0] np, input logic roll, input logic exp_ok,
                       input logic [3:0] exp_err, input logic [15:0] exp_bal);
    op_valid = 1'b1; op_code = code; amount = amt; new_pin = np;
    @(negedge clk);
    op_valid = 1'b0;
    day_rollover = roll;
    @(negedge clk);
    day_rollover = 1'b0;
    chk({tag, " resp_valid"}, resp_valid, 1);
    chk({tag, " resp_ok"}, resp_ok, exp_ok);
    chk({tag, " error"}, error_code, exp_err);
    chk({tag, " balance"}, balance_out, exp_bal);
    @(negedge clk);
    chk({tag, " back to menu"}, state_o, 4);
  endtask

  initial begin
    rst_n = 1'b0; card_inserted = 1'b0; card_id = '0; pin_valid = 1'b0; pin_in = '0;
    op_valid = 1'b0; op_code = '0; amount = '0; new_pin = '0; day_rollover = 1'b0;
    cfg_we = 1'b0; cfg_card = '0; cfg_pin = '0; cfg_balance = '0; cfg_limit = '0; cfg_active = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset state", state_o, 0);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset error", error_code, 0);
    chk("reset balance", balance_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Card 2: basic session, limit accounting, rollover
    cfg(4'd2, 16'd1234, 16'd500, 16'd300, 1'b1);
    insert(4'd2);
    chk("card2 pin_wait", state_o, 2);
    enter_pin(16'd1234);
    chk("card2 menu", state_o, 4);
    do_op("bal", 2'd0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd0, 16'd500);
    do_op("wdr200", 2'd1, 16'd200, 16'd0, 1'b0, 1'b1, 4'd0, 16'd300);
    do_op("wdr150 limit", 2'd1, 16'd150, 16'd0, 1'b0, 1'b0, 4'd5, 16'd300);
    day_rollover = 1'b1;
    @(negedge clk);
    day_rollover = 1'b0;
    do_op("wdr150 after roll", 2'd1, 16'd150, 16'd0, 1'b0, 1'b1, 4'd0, 16'd150);
    do_op("dep1000", 2'd2, 16'd1000, 16'd0, 1'b0, 1'b1, 4'd0, 16'd1150);
    do_op("wdr160 roll same cyc", 2'd1, 16'd160, 16'd0, 1'b1, 1'b1, 4'd0, 16'd990);
    do_op("wdr150 spent160", 2'd1, 16'd150, 16'd0, 1'b0, 1'b0, 4'd5, 16'd990);
    do_op("wdr1000 limit first", 2'd1, 16'd1000, 16'd0, 1'b0, 1'b0, 4'd5, 16'd990);
    do_op("pinchg", 2'd3, 16'd0, 16'd4321, 1'b0, 1'b1, 4'd0, 16'd990);
    remove();

    insert(4'd2);
    enter_pin(16'd4321);
    chk("new pin accepted", state_o, 4);
    remove();

    // Lockout after three bad PINs
    insert(4'd2);
    enter_pin(16'd1234);
    chk("bad pin1 state", state_o, 2);
    chk("bad pin1 error", error_code, 2);
    enter_pin(16'd1111);
    chk("bad pin2 state", state_o, 2);
    chk("bad pin2 error", error_code, 2);
    enter_pin(16'd2222);
    chk("bad pin3 state", state_o, 7);
    chk("bad pin3 error", error_code, 3);
    remove();
    insert(4'd2);
    chk("locked card state", state_o, 7);
    chk("locked card error", error_code, 1);
    remove();

    // Card 5 configured in the same cycle as insertion
    cfg_we = 1'b1; cfg_card = 4'd5; cfg_pin = 16'd7; cfg_balance = 16'hFFF0;
    cfg_limit = 16'hFFFF; cfg_active = 1'b1;
    card_inserted = 1'b1; card_id = 4'd5;
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    chk("cfg+insert pin_wait", state_o, 2);
    enter_pin(16'd7);
    chk("card5 menu", state_o, 4);
    do_op("wdr insuf", 2'd1, 16'hFFF1, 16'd0, 1'b0, 1'b0, 4'd4, 16'd990);
    do_op("dep overflow", 2'd2, 16'h0020, 16'd0, 1'b0, 1'b0, 4'd6, 16'd990);
    cfg(4'd5, 16'd9, 16'd0, 16'd0, 1'b0);
    do_op("dep to max", 2'd2, 16'h000F, 16'd0, 1'b0, 1'b1, 4'd0, 16'hFFFF);
    do_op("bal after drop cfg", 2'd0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd0, 16'hFFFF);

    // Card pulled during EXEC: op still commits and responds, then IDLE
    op_valid = 1'b1; op_code = 2'd1; amount = 16'd50;
    @(negedge clk);
    op_valid = 1'b0;
    card_inserted = 1'b0;
    chk("exec state", state_o, 5);
    @(negedge clk);
    chk("pulled resp_valid", resp_valid, 1);
    chk("pulled resp_ok", resp_ok, 1);
    chk("pulled balance", balance_out, 16'hFFCD);
    @(negedge clk);
    chk("pulled idle", state_o, 0);
    chk("pulled resp cleared", resp_valid, 0);

    // Inactivity timeout in MENU
    insert(4'd5);
    enter_pin(16'd7);
    chk("tmo menu", state_o, 4);
    repeat (7) @(negedge clk);
    chk("tmo still menu", state_o, 4);
    @(negedge clk);
    chk("tmo error state", state_o, 7);
    chk("tmo error code", error_code, 7);
    remove();

    // Reset mid-session
    insert(4'd5);
    enter_pin(16'd7);
    do_op("bal before reset", 2'd0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd0, 16'hFFCD);
    rst_n = 1'b0;
    #1;
    chk("mid reset state", state_o, 0);
    chk("mid reset resp_ok", resp_ok, 0);
    chk("mid reset balance", balance_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post reset table cleared", state_o, 7);
    chk("post reset invalid", error_code, 1);
    remove();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
